alu_muldiv_controller: RTL and testbench

Second-generation ALU controller: XLEN-parametrised decode of RV32I R/I/load/store instructions into the ALU op code, plus a sequential engine for the RV32M multiply/divide group. Sits in the execute stage beside the ALU. Base ops decode combinationally with zero latency. M-extension ops run on an iterative shift-add multiplier / restoring divider, which stalls the pipeline until the result is ready.

---
 rtl/alu_muldiv_controller_pkg.sv | 40 ++++
 rtl/alu_muldiv_controller_muldiv_core.sv | 122 ++++++++++++
 rtl/alu_muldiv_controller.sv | 67 ++++++
 tb/tb_alu_muldiv_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_controller_pkg.sv
// Shared encodings for the execute-stage ALU controller: RV32 opcodes, ALU op
// codes, RV32M func3 codes and the multiply/divide sequencer states.
package alu_muldiv_controller_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] MFUNC7   = 7'b0000001;

  typedef enum logic [3:0] {
    ALUADD  = 4'd0,
    ALUSUB  = 4'd1,
    ALUXOR  = 4'd2,
    ALUOR   = 4'd3,
    ALUAND  = 4'd4,
    ALUSLL  = 4'd5,
    ALUSRL  = 4'd6,
    ALUSRA  = 4'd7,
    ALUSLT  = 4'd8,
    ALUSLTU = 4'd9
  } aluop_e;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } mfunc_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } md_state_e;

endpackage

// File: rtl/alu_muldiv_controller_muldiv_core.sv
// Iterative RV32M engine: shift-add multiplier and restoring divider on operand
// magnitudes, with the sign applied to the final result.
module muldiv_core
  import alu_muldiv_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state, state_next;
  mfunc_e            op, op_in;
  logic              neg;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;

  logic              accept, s1, s2, neg_in, div_zero, ovf;
  logic [XLEN-1:0]   mag1, mag2, spec_res;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] step, prod;
  logic [XLEN-1:0]   quo, rmd, final_res;

  assign op_in  = mfunc_e'(func3);
  assign accept = start & ~flush;

  // Operand conditioning at accept: magnitudes, result sign, divide corner cases.
  always_comb begin
    s1       = 1'b0;
    s2       = 1'b0;
    neg_in   = 1'b0;
    div_zero = 1'b0;
    ovf      = 1'b0;
    spec_res = '0;
    if (op_in inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM}) s1 = rs1[XLEN-1];
    if (op_in inside {M_MUL, M_MULH, M_DIV, M_REM})           s2 = rs2[XLEN-1];
    mag1     = s1 ? -rs1 : rs1;
    mag2     = s2 ? -rs2 : rs2;
    neg_in   = (func3[2] & func3[1]) ? s1 : (s1 ^ s2);
    div_zero = func3[2] & (rs2 == '0);
    ovf      = func3[2] & ~func3[0] & (rs1 == SMIN) & (rs2 == '1);
    if (div_zero)  spec_res = func3[1] ? rs1 : '1;
    else if (ovf)  spec_res = func3[1] ? '0 : SMIN;
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_sh - {1'b0, opb};
    if (state == S_DIV)
      step = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                            : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      step = {mul_sum, acc[XLEN-1:1]};
    prod = neg ? -step : step;
    quo  = neg ? -step[XLEN-1:0] : step[XLEN-1:0];
    rmd  = neg ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    if (state == S_MUL)
      final_res = (op == M_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else
      final_res = op[1] ? rmd : quo;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept)
                state_next = (div_zero | ovf) ? S_DONE : (func3[2] ? S_DIV : S_MUL);
      S_MUL, S_DIV: begin
        if (flush)             state_next = S_IDLE;
        else if (count == '0)  state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign md_done = (state == S_DONE) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      acc       <= '0;
      opb       <= '0;
      op        <= M_MUL;
      neg       <= 1'b0;
      md_result <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (accept) begin
          op    <= op_in;
          neg   <= neg_in;
          opb   <= mag2;
          acc   <= {{XLEN{1'b0}}, mag1};
          count <= CW'(XLEN - 1);
          if (div_zero | ovf) md_result <= spec_res;
        end
        S_MUL, S_DIV: if (!flush) begin
          acc   <= step;
          count <= count - 1'b1;
          if (count == '0) md_result <= final_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv_controller.sv
// Execute-stage ALU controller: zero-latency RV32I base decode to an ALU op
// code, plus stall generation around the iterative RV32M engine.
module alu_muldiv_controller
  import alu_muldiv_controller_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IWIDTH = 17,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IWIDTH-1:0] instruction,
  input  logic              valid,
  input  logic              flush,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic [AWIDTH-1:0] aluop,
  output logic              stall,
  output logic              md_done,
  output logic [XLEN-1:0]   md_result
);

  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic       m_req;
  aluop_e     alu_sel;

  assign opcode = instruction[6:0];
  assign func3  = instruction[9:7];
  assign func7  = instruction[16:10];

  // Only R-type has a SUB form; for I-type func7[5] is an immediate bit except on SRAI.
  always_comb begin
    alu_sel = ALUADD;
    if (opcode == OP_ITYPE || (opcode == OP_RTYPE && func7 != MFUNC7)) begin
      case (func3)
        3'b000: alu_sel = (opcode == OP_RTYPE && func7[5]) ? ALUSUB : ALUADD;
        3'b001: alu_sel = ALUSLL;
        3'b010: alu_sel = ALUSLT;
        3'b011: alu_sel = ALUSLTU;
        3'b100: alu_sel = ALUXOR;
        3'b101: alu_sel = func7[5] ? ALUSRA : ALUSRL;
        3'b110: alu_sel = ALUOR;
        default: alu_sel = ALUAND;
      endcase
    end
  end

  assign aluop = AWIDTH'(alu_sel);
  assign m_req = valid & (opcode == OP_RTYPE) & (func7 == MFUNC7);
  assign stall = m_req & ~md_done;

  muldiv_core #(
    .XLEN(XLEN)
  ) u_muldiv_core (
    .clk       (clk),
    .rst       (rst),
    .start     (m_req),
    .flush     (flush),
    .func3     (func3),
    .rs1       (rs1),
    .rs2       (rs2),
    .md_done   (md_done),
    .md_result (md_result)
  );

endmodule

// File: tb/tb_alu_muldiv_controller.sv
// Self-checking bench: per-cycle comparison against a behavioural model of the
// decode, stall and M-op timing/results, plus literal expectations.
module tb_alu_muldiv_controller;
  import alu_muldiv_controller_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, flush = 1'b0;
  logic [16:0] instruction = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [3:0]  aluop;
  logic        stall, md_done;
  logic [31:0] md_result;

  int          checks = 0, errors = 0, cyc = 0, exp_done_cyc = -1;
  logic [31:0] exp_res = '0, last_res = '0;

  alu_muldiv_controller #(
    .XLEN(XLEN),
    .IWIDTH(17),
    .AWIDTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .valid       (valid),
    .flush       (flush),
    .rs1         (rs1),
    .rs2         (rs2),
    .aluop       (aluop),
    .stall       (stall),
    .md_done     (md_done),
    .md_result   (md_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic aluop_e ref_alu(input logic [16:0] ins);
    aluop_e     by_f3 [8];
    logic [6:0] opc, f7;
    logic [2:0] f3;
    by_f3 = '{ALUADD, ALUSLL, ALUSLT, ALUSLTU, ALUXOR, ALUSRL, ALUOR, ALUAND};
    opc = ins[6:0];
    f3  = ins[9:7];
    f7  = ins[16:10];
    if (!(opc == OP_ITYPE || (opc == OP_RTYPE && f7 != MFUNC7))) return ALUADD;
    if (f3 == 3'd5 && f7[5]) return ALUSRA;
    if (f3 == 3'd0 && f7[5] && opc == OP_RTYPE) return ALUSUB;
    return by_f3[f3];
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          si, sj;
    logic        ovf;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    si = $signed(a);
    sj = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(si / sj);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(si % sj);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      automatic logic done_now = (cyc == exp_done_cyc);
      automatic logic mreq = valid && instruction[6:0] == OP_RTYPE && instruction[16:10] == MFUNC7;
      chk("aluop", 32'(aluop), 32'(ref_alu(instruction)));
      chk("md_done", 32'(md_done), 32'(done_now));
      chk("stall", 32'(stall), 32'(mreq && !done_now));
      if (done_now) last_res = exp_res;
      chk("md_result", md_result, last_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0;
    flush = 1'b0;
    instruction = '0;
  endtask

  task automatic start_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, output int lat);
    logic special;
    special = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    instruction = {MFUNC7, f3, OP_RTYPE};
    rs1 = a;
    rs2 = b;
    valid = 1'b1;
    flush = 1'b0;
    lat = special ? 1 : XLEN + 1;
    exp_res = ref_md(f3, a, b);
    exp_done_cyc = cyc + lat;
  endtask

  task automatic run_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input string name, input logic has_lit, input logic [31:0] lit);
    int lat;
    start_m(f3, a, b, lat);
    repeat (lat) tick();
    chk({name, "_done"}, 32'(md_done), 32'd1);
    if (has_lit) chk(name, md_result, lit);
    tick();
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_base();
    logic [6:0] opc, f7;
    logic [2:0] f3;
    case ($urandom_range(0, 4))
      0: opc = OP_RTYPE;
      1: opc = OP_ITYPE;
      2: opc = 7'b0000011;
      3: opc = 7'b0100011;
      default: opc = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = MFUNC7;
      default: f7 = 7'($urandom);
    endcase
    f3 = 3'($urandom);
    instruction = {f7, f3, opc};
    rs1 = $urandom;
    rs2 = $urandom;
    flush = ($urandom_range(0, 3) == 0);
    valid = (opc == OP_RTYPE && f7 == MFUNC7) ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  initial begin
    int lat;
    tick();
    tick();
    chk("rst_md_done", 32'(md_done), 32'd0);
    chk("rst_md_result", md_result, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    instruction = {MFUNC7, 3'b000, OP_RTYPE};
    valid = 1'b1;
    #1;
    chk("rst_stall_mreq", 32'(stall), 32'd1);
    idle();
    tick();
    rst = 1'b0;
    tick();

    instruction = {7'b0000000, 3'b000, OP_RTYPE}; valid = 1'b1; #1;
    chk("dec_add", 32'(aluop), 32'(ALUADD));
    chk("dec_add_stall", 32'(stall), 32'd0);
    tick();
    instruction = {7'b0100000, 3'b000, OP_RTYPE}; #1;
    chk("dec_sub", 32'(aluop), 32'(ALUSUB));
    chk("dec_sub_stall", 32'(stall), 32'd0);
    tick();
    instruction = {7'b0100000, 3'b101, OP_ITYPE}; #1;
    chk("dec_srai", 32'(aluop), 32'(ALUSRA));
    chk("dec_srai_stall", 32'(stall), 32'd0);
    tick();

    run_m(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3", 1'b1, 32'hFFFF_FFEB);
    run_m(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_corner", 1'b1, 32'hFFFF_FFFE);
    run_m(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_corner", 1'b1, 32'h0000_0000);
    run_m(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_corner", 1'b1, 32'hFFFF_FFFF);
    run_m(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b1, 32'hFFFF_FFFD);
    run_m(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2", 1'b1, 32'hFFFF_FFFF);
    run_m(3'd5, 32'd7, 32'd0, "divu_by0", 1'b1, 32'hFFFF_FFFF);
    run_m(3'd7, 32'd7, 32'd0, "remu_by0", 1'b1, 32'd7);
    run_m(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1, 32'h8000_0000);
    run_m(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b1, 32'h0);
    // back-to-back with no idle cycle between the two
    run_m(3'd0, 32'd3, 32'd5, "b2b_mul1", 1'b1, 32'd15);
    run_m(3'd0, 32'h0001_2345, 32'h100, "b2b_mul2", 1'b1, 32'h0123_4500);

    // flush in cycle 10 of a DIV; a new op presented in cycle 11 must be accepted
    start_m(3'd4, 32'd100, 32'd7, lat);
    repeat (10) tick();
    flush = 1'b1;
    exp_done_cyc = -1;
    tick();
    run_m(3'd0, 32'd6, 32'd7, "after_flush", 1'b1, 32'd42);

    // asynchronous reset in the middle of a MUL
    start_m(3'd0, 32'd9, 32'd9, lat);
    repeat (15) tick();
    #2;
    rst = 1'b1;
    idle();
    exp_done_cyc = -1;
    last_res = '0;
    #1;
    chk("midrst_md_result", md_result, 32'h0);
    chk("midrst_md_done", 32'(md_done), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    tick();
    rst = 1'b0;
    run_m(3'd0, 32'd11, 32'd13, "after_rst", 1'b1, 32'd143);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(1, 3)) begin
        rand_base();
        tick();
      end
      run_m(3'($urandom), rnd_opnd(), rnd_opnd(), "rand_m", 1'b0, 32'h0);
    end
    idle();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
